// File: rtl/svm_detect_collector.sv
// Pairs SVM window scores with their queued coordinates, thresholds them into a
// first-word fall-through detection FIFO and publishes per-frame statistics.
module svm_detect_collector #(
  parameter int                        SCORE_W    = 22,
  parameter int                        COORD_W    = 11,
  parameter logic signed [SCORE_W-1:0] THRESHOLD  = 22'sd0,
  parameter int                        TAG_DEPTH  = 4,
  parameter int                        FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               win_start,
  input  logic [COORD_W-1:0] win_x,
  input  logic [COORD_W-1:0] win_y,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  input  logic               frame_end,
  output logic               det_valid,
  input  logic               det_ready,
  output logic [COORD_W-1:0] det_x,
  output logic [COORD_W-1:0] det_y,
  output logic [SCORE_W-1:0] det_score,
  output logic               frame_done,
  output logic [7:0]         frame_det_count,
  output logic [7:0]         frame_drop_count,
  output logic               frame_best_valid,
  output logic [SCORE_W-1:0] frame_best_score,
  output logic [COORD_W-1:0] frame_best_x,
  output logic [COORD_W-1:0] frame_best_y,
  output logic               tag_err
);

  localparam int TAG_AW  = $clog2(TAG_DEPTH);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  logic [COORD_W-1:0] tag_x_mem [TAG_DEPTH];
  logic [COORD_W-1:0] tag_y_mem [TAG_DEPTH];
  logic [TAG_AW:0]    tag_wr, tag_rd;
  logic               tag_empty, tag_full;
  logic               tag_push_ok, tag_pop_ok, tag_bypass, tag_wr_en, tag_rd_en;
  logic               tag_push_err, tag_pop_err;
  logic [COORD_W-1:0] cur_x, cur_y;

  logic [COORD_W-1:0] det_x_mem [FIFO_DEPTH];
  logic [COORD_W-1:0] det_y_mem [FIFO_DEPTH];
  logic [SCORE_W-1:0] det_s_mem [FIFO_DEPTH];
  logic [FIFO_AW:0]   det_wr, det_rd;
  logic               det_full, det_pop, is_det, det_wr_en, det_drop;

  logic [7:0]                run_cnt, run_drop, run_cnt_nxt, run_drop_nxt;
  logic                      run_best_valid, run_best_valid_nxt, best_upd;
  logic signed [SCORE_W-1:0] run_best_score, run_best_score_nxt;
  logic [COORD_W-1:0]        run_best_x, run_best_y, run_best_x_nxt, run_best_y_nxt;

  assign tag_empty = (tag_wr == tag_rd);
  assign tag_full  = (tag_wr[TAG_AW] != tag_rd[TAG_AW]) &&
                     (tag_wr[TAG_AW-1:0] == tag_rd[TAG_AW-1:0]);

  // A simultaneous pop frees the slot a full-queue push needs; an empty-queue
  // pop is served straight from the incoming coordinates.
  assign tag_push_ok  = win_start && (!tag_full || score_valid);
  assign tag_pop_ok   = score_valid && (!tag_empty || win_start);
  assign tag_bypass   = win_start && score_valid && tag_empty;
  assign tag_wr_en    = tag_push_ok && !tag_bypass;
  assign tag_rd_en    = tag_pop_ok && !tag_bypass;
  assign tag_push_err = win_start && !tag_push_ok;
  assign tag_pop_err  = score_valid && !tag_pop_ok;
  assign cur_x = tag_bypass ? win_x : tag_x_mem[tag_rd[TAG_AW-1:0]];
  assign cur_y = tag_bypass ? win_y : tag_y_mem[tag_rd[TAG_AW-1:0]];

  assign det_valid = (det_wr != det_rd);
  assign det_full  = (det_wr[FIFO_AW] != det_rd[FIFO_AW]) &&
                     (det_wr[FIFO_AW-1:0] == det_rd[FIFO_AW-1:0]);
  assign det_pop   = det_valid && det_ready;
  assign is_det    = tag_pop_ok && ($signed(score) > THRESHOLD);
  assign det_wr_en = is_det && (!det_full || det_pop);
  assign det_drop  = is_det && !det_wr_en;
  assign det_x     = det_x_mem[det_rd[FIFO_AW-1:0]];
  assign det_y     = det_y_mem[det_rd[FIFO_AW-1:0]];
  assign det_score = det_s_mem[det_rd[FIFO_AW-1:0]];

  // Dropped detections still count and still compete for best.
  assign best_upd = is_det && (!run_best_valid || ($signed(score) > run_best_score));

  always_comb begin
    run_cnt_nxt        = run_cnt;
    run_drop_nxt       = run_drop;
    run_best_valid_nxt = run_best_valid;
    run_best_score_nxt = run_best_score;
    run_best_x_nxt     = run_best_x;
    run_best_y_nxt     = run_best_y;
    if (is_det && run_cnt != 8'hFF)
      run_cnt_nxt = run_cnt + 8'd1;
    if (det_drop && run_drop != 8'hFF)
      run_drop_nxt = run_drop + 8'd1;
    if (best_upd) begin
      run_best_valid_nxt = 1'b1;
      run_best_score_nxt = $signed(score);
      run_best_x_nxt     = cur_x;
      run_best_y_nxt     = cur_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= '0;
      tag_rd <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_x_mem[i] <= '0;
        tag_y_mem[i] <= '0;
      end
      det_wr <= '0;
      det_rd <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        det_x_mem[i] <= '0;
        det_y_mem[i] <= '0;
        det_s_mem[i] <= '0;
      end
      tag_err          <= 1'b0;
      run_cnt          <= '0;
      run_drop         <= '0;
      run_best_valid   <= 1'b0;
      run_best_score   <= '0;
      run_best_x       <= '0;
      run_best_y       <= '0;
      frame_done       <= 1'b0;
      frame_det_count  <= '0;
      frame_drop_count <= '0;
      frame_best_valid <= 1'b0;
      frame_best_score <= '0;
      frame_best_x     <= '0;
      frame_best_y     <= '0;
    end else begin
      if (tag_wr_en) begin
        tag_x_mem[tag_wr[TAG_AW-1:0]] <= win_x;
        tag_y_mem[tag_wr[TAG_AW-1:0]] <= win_y;
        tag_wr <= tag_wr + 1'b1;
      end
      if (tag_rd_en)
        tag_rd <= tag_rd + 1'b1;
      if (tag_push_err || tag_pop_err)
        tag_err <= 1'b1;

      if (det_wr_en) begin
        det_x_mem[det_wr[FIFO_AW-1:0]] <= cur_x;
        det_y_mem[det_wr[FIFO_AW-1:0]] <= cur_y;
        det_s_mem[det_wr[FIFO_AW-1:0]] <= score;
        det_wr <= det_wr + 1'b1;
      end
      if (det_pop)
        det_rd <= det_rd + 1'b1;

      // The frame_end cycle's own score is folded in before publishing.
      frame_done <= frame_end;
      if (frame_end) begin
        frame_det_count  <= run_cnt_nxt;
        frame_drop_count <= run_drop_nxt;
        frame_best_valid <= run_best_valid_nxt;
        frame_best_score <= run_best_score_nxt;
        frame_best_x     <= run_best_x_nxt;
        frame_best_y     <= run_best_y_nxt;
        run_cnt          <= '0;
        run_drop         <= '0;
        run_best_valid   <= 1'b0;
        run_best_score   <= '0;
        run_best_x       <= '0;
        run_best_y       <= '0;
      end else begin
        run_cnt          <= run_cnt_nxt;
        run_drop         <= run_drop_nxt;
        run_best_valid   <= run_best_valid_nxt;
        run_best_score   <= run_best_score_nxt;
        run_best_x       <= run_best_x_nxt;
        run_best_y       <= run_best_y_nxt;
      end
    end
  end

endmodule

// File: doc/svm_detect_collector.md
Name: svm_detect_collector

Overview:
- Consumes the per-window score stream from the SVM classifier: a 22-bit s8c13f score with a one-cycle valid pulse.
- Pairs each score with the window coordinates captured when that window's feature stream started, and thresholds the score.
- Queues accepted detections in an output FIFO for the downstream box-drawing/reporting logic.
- Keeps per-frame statistics (count, drops, best detection) and publishes them on frame_end.

Parameters:
SCORE_W, 22, score width, signed s8c13f
COORD_W, 11, width of window x/y coordinates
THRESHOLD, 22'sd0, signed detection threshold in s8c13f
TAG_DEPTH, 4, coordinate queue depth (power of 2)
FIFO_DEPTH, 16, detection FIFO depth (power of 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
win_start  in  1  one-cycle pulse: window feature stream starts; win_x/win_y valid
win_x  in  COORD_W  window x coordinate
win_y  in  COORD_W  window y coordinate
score  in  SCORE_W  signed SVM score, s8c13f
score_valid  in  1  one-cycle pulse, score valid
frame_end  in  1  one-cycle pulse, last window of the frame has been scored
det_valid  out  1  detection FIFO non-empty
det_ready  in  1  downstream accepts the head entry
det_x  out  COORD_W  head entry x
det_y  out  COORD_W  head entry y
det_score  out  SCORE_W  head entry score
frame_done  out  1  one-cycle pulse, frame statistics valid
frame_det_count  out  8  detections accepted in the frame, saturating at 255
frame_drop_count  out  8  detections dropped because the FIFO was full, saturating at 255
frame_best_valid  out  1  at least one detection in the frame
frame_best_score  out  SCORE_W  highest detection score in the frame
frame_best_x  out  COORD_W  x of the best detection
frame_best_y  out  COORD_W  y of the best detection
tag_err  out  1  sticky error flag, cleared only by reset

Behaviour:
Reset:
- rst_n low clears all outputs, queues, counters and tag_err to 0, asynchronously.
- Reset mid-frame discards all in-flight coordinates and queued detections.

Coordinate queue (TAG_DEPTH, FIFO order):
- win_start pushes {win_x, win_y}; score_valid pops the oldest entry.
- Push and pop in the same cycle are both performed, including when the queue is full or empty (bypass: the popped coordinates are the pushed ones).
- Push when full with no simultaneous pop: the push is ignored and tag_err is set.
- score_valid with the queue empty and no simultaneous push: the score is discarded and tag_err is set.

Detection:
- On score_valid, a score is a detection iff $signed(score) > THRESHOLD (strict).
- Non-detections leave no trace except consuming their coordinate entry.
- An accepted detection writes {x, y, score} to the detection FIFO.
- FIFO full with a det_valid&det_ready pop in the same cycle: the write succeeds.
- FIFO full with no pop: the detection is dropped and frame_drop_count increments; it still counts for best tracking.

Detection FIFO:
- First-word fall-through; det_valid = !empty; an entry transfers when det_valid & det_ready.
- Latency: score_valid at cycle t with the FIFO empty gives det_valid=1 at t+1 with that entry on det_x/det_y/det_score.
- Read and write pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- The FIFO is not flushed on frame_end.

Frame statistics:
- Running count, drops and best are kept internally.
- Best is updated only on a strictly greater detection score, so the first of equal scores wins.
- A score_valid coinciding with frame_end belongs to the ending frame.
- At the cycle after frame_end:
  - frame_done pulses and the frame_* outputs present the final values.
  - frame_* outputs hold until the next frame_done.
  - Running stats are cleared for the next frame.
- A score_valid in that clearing cycle counts toward the new frame.
- The coordinate queue is not cleared on frame_end.
- Counters saturate at 255, never wrap.

Test Plan:
- Reset then win_start (x=10,y=20), score=+0x000800 eight cycles later, det_ready=1 -> det_valid high one cycle after score_valid with det_x=10, det_y=20, det_score=0x000800; frame_end -> frame_det_count=1, frame_best_valid=1, best=(10,20,0x000800).
- Scores 0, -1 (0x3FFFFF), +1 with THRESHOLD=0 -> only +1 is queued; frame_det_count=1.
- det_ready=0, 18 detections -> 16 in the FIFO, frame_drop_count=2, det_valid held; then det_ready=1 -> 16 entries drain in order.
- FIFO full with simultaneous pop and detection -> no drop, occupancy stays 16.
- Two equal best scores at (1,1) then (2,2), then a higher score at (3,3) -> best=(3,3); without the third score, best=(1,1).
- score_valid with the coordinate queue empty -> tag_err=1, nothing queued; five win_start pulses with no scores -> tag_err=1; after reset, tag_err=0.
